llr_slow_iq_collector: RTL and testbench
========================================

// Module: llr_slow_iq_collector
// PURPOSE
//  LLR-side sink of the slow PHY-to-LLR interface. Qualifies each data strobe, repacks RE pairs into
//  128-bit IQ words and rate-decimated noise samples into 128-bit noise words, and writes both into
//  LLR input FIFOs. Tracks the per-user RE budget, flushes partial words at user end, flags overflow.
// PARAMETERS
//  DW      16   sample width (I, Q, noise)
//  WORD_W  128  FIFO word width; fixed at 8*DW
//  CNT_W   16   width of RE/rate counters
// PORTS
//  i_core_clk             in   1      single clock
//  i_rx_rstn              in   1      asynchronous active-low reset
//  i_user_start           in   1      1-cycle pulse: latch user config, begin collecting
//  i_cur_user_re_amounts  in   CNT_W  REs for this user (>=1)
//  i_user_iq_noise_rate   in   CNT_W  strobes per noise sample = rate>>1; rate even, >=2
//  i_data_strobe          in   1      RE pair + noise valid this cycle
//  i_re0_data_i/_q        in   DW     first RE of pair
//  i_re1_data_i/_q        in   DW     second RE of pair
//  i_noise_data           in   DW     noise sample
//  i_iq_fifo_full         in   1      IQ FIFO full
//  i_noise_fifo_full      in   1      noise FIFO full
//  o_iq_fifo_wr_en        out  1      IQ word write
//  o_iq_fifo_wr_data      out  WORD_W IQ word
//  o_noise_fifo_wr_en     out  1      noise word write
//  o_noise_fifo_wr_data   out  WORD_W noise word
//  o_busy                 out  1      state != IDLE
//  o_user_done            out  1      1-cycle pulse, user complete and flushed
//  o_overflow             out  1      sticky: word dropped on full FIFO; cleared by i_user_start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters and partial words cleared.
//  States: IDLE -(i_user_start)-> COLLECT -(RE budget met)-> FLUSH -> DONE -> IDLE.
//  i_user_start in any non-IDLE state: discard partials, reload config, go COLLECT (restart, no done).
//  Strobes outside COLLECT ignored.
//  IQ packing, per word: beat0 {re1_q,re1_i,re0_q,re0_i} -> [63:0]; beat1 same order -> [127:64].
//   Write issued the cycle after beat1 strobe (1-cycle registered latency).
//  Noise: sample i_noise_data on strobe 0 of every group of (rate>>1) strobes; 8 samples per word,
//   sample k -> [16k+15:16k]; write the cycle after the 8th sample.
//  RE count +2 per strobe; COLLECT->FLUSH on the strobe where count >= i_cur_user_re_amounts.
//   Odd amount: re1 of final strobe is kept as received (padding, LLR ignores it).
//  FLUSH (1 cycle): write any partial IQ word (beat1 zeroed) and partial noise word (unused lanes
//   zero); both writes may occur in the same cycle. No partial -> no write.
//  DONE: o_user_done=1 for one cycle.
//  Write while corresponding FIFO full: wr_en held 0, word dropped, o_overflow set; counting continues.
//  Config latched at i_user_start; mid-user config changes ignored. Counters wrap-free (CNT_W).
//  Async reset mid-user: immediate return to IDLE, no flush, no done.
// STRUCTURE
//  Package llr_slow_pkg: state localparams (one-hot IDLE/COLLECT/FLUSH/DONE), DW, WORD_W, lane counts.
//  Sub-module llr_lane_packer (#LANE_W, #LANES): shift-in lanes, o_full, flush with zero fill;
//   instantiated for IQ (LANE_W=64, LANES=2) and noise (LANE_W=16, LANES=8).
// TESTING
//  1 amounts=8, rate=2, 4 back-to-back strobes -> 2 IQ writes, 4 noise samples, FLUSH writes
//    partial noise with [127:64]=0, o_user_done 1 cycle after FLUSH.
//  2 amounts=6, rate=4, strobe every other cycle -> IQ write 1 cycle after strobe 2, flush IQ with
//    [127:64]=0; noise lanes 0,1 from strobes 0,2.
//  3 amounts=32, rate=2, i_iq_fifo_full=1 during 2nd word -> that word dropped, o_overflow=1, 4th ok.
//  4 i_user_start mid-COLLECT after 3 strobes -> no writes from stale partials, no o_user_done.
//  5 amounts=32, rate=2, noise word completes on final strobe -> noise write once, FLUSH writes none.
//  6 i_rx_rstn low mid-user -> all outputs 0 asynchronously; strobes before new start ignored.

Source files
------------

// File: rtl/llr_slow_iq_collector_pkg.sv
// Shared constants for the LLR-side slow interface collector: sample/word widths,
// lane geometry of the two packers and the one-hot FSM encoding.
package llr_slow_pkg;

    localparam int DW          = 16;
    localparam int WORD_W      = 8 * DW;
    localparam int IQ_LANE_W   = 4 * DW;
    localparam int IQ_LANES    = WORD_W / IQ_LANE_W;
    localparam int NOISE_LANE_W = DW;
    localparam int NOISE_LANES  = WORD_W / NOISE_LANE_W;

    localparam logic [3:0] ST_IDLE    = 4'b0001;
    localparam logic [3:0] ST_COLLECT = 4'b0010;
    localparam logic [3:0] ST_FLUSH   = 4'b0100;
    localparam logic [3:0] ST_DONE    = 4'b1000;

    // One RE pair as it lands in an IQ word lane: {re1_q, re1_i, re0_q, re0_i}.
    function automatic logic [IQ_LANE_W-1:0] pack_iq_beat(
        input logic [DW-1:0] re0_i, input logic [DW-1:0] re0_q,
        input logic [DW-1:0] re1_i, input logic [DW-1:0] re1_q);
        return {re1_q, re1_i, re0_q, re0_i};
    endfunction

endpackage

// File: rtl/llr_slow_iq_collector_if.sv
// Slow PHY-to-LLR data bus: one strobe qualifies an RE pair and a noise sample.
interface llr_slow_iq_collector_if;
    import llr_slow_pkg::*;

    logic          data_strobe;
    logic [DW-1:0] re0_data_i;
    logic [DW-1:0] re0_data_q;
    logic [DW-1:0] re1_data_i;
    logic [DW-1:0] re1_data_q;
    logic [DW-1:0] noise_data;

    modport master (output data_strobe, re0_data_i, re0_data_q, re1_data_i, re1_data_q, noise_data);
    modport slave  (input  data_strobe, re0_data_i, re0_data_q, re1_data_i, re1_data_q, noise_data);

endinterface

// File: rtl/llr_lane_packer.sv
// Fills a word lane by lane from lane 0 upward; emits it one cycle after the last lane
// or, on flush, emits a partial word whose unused lanes are zero.
module llr_lane_packer #(
    parameter int LANE_W = 16,
    parameter int LANES  = 8
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_clear,
    input  logic                     i_shift,
    input  logic                     i_flush,
    input  logic [LANE_W-1:0]        i_lane,
    output logic                     o_full,
    output logic [LANE_W*LANES-1:0]  o_word
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][LANE_W-1:0] lanes_q;
    logic [LANES-1:0][LANE_W-1:0] lanes_next;
    logic [IDX_W-1:0]             idx_q;

    // NOTE: assign the whole variable first so every path drives it and no latch is inferred.
    always_comb begin
        lanes_next        = lanes_q;
        lanes_next[idx_q] = i_lane;
    end

    // NOTE: the lane storage is reset too, so a flushed partial word always zero-fills
    // lanes that were never written; non-blocking assignments keep every register
    // updating from the pre-edge values.
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            lanes_q <= '0;
            idx_q   <= '0;
            o_full  <= 1'b0;
            o_word  <= '0;
        end else begin
            o_full <= 1'b0;
            if (i_clear) begin
                lanes_q <= '0;
                idx_q   <= '0;
            end else if (i_shift) begin
                if (idx_q == IDX_W'(LANES - 1)) begin
                    o_word  <= lanes_next;
                    o_full  <= 1'b1;
                    lanes_q <= '0;
                    idx_q   <= '0;
                end else begin
                    lanes_q <= lanes_next;
                    idx_q   <= idx_q + 1'b1;
                end
            end else if (i_flush && (idx_q != '0)) begin
                o_word  <= lanes_q;
                o_full  <= 1'b1;
                lanes_q <= '0;
                idx_q   <= '0;
            end
        end
    end

endmodule

// File: rtl/llr_slow_iq_collector.sv
// LLR-side sink of the slow PHY interface: packs RE pairs into IQ words and decimated
// noise samples into noise words, tracks the per-user RE budget and flushes at user end.
module llr_slow_iq_collector
    import llr_slow_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    i_core_clk,
    input  logic                    i_rx_rstn,
    input  logic                    i_user_start,
    input  logic [CNT_W-1:0]        i_cur_user_re_amounts,
    input  logic [CNT_W-1:0]        i_user_iq_noise_rate,
    llr_slow_iq_collector_if.slave  phy,
    input  logic                    i_iq_fifo_full,
    input  logic                    i_noise_fifo_full,
    output logic                    o_iq_fifo_wr_en,
    output logic [WORD_W-1:0]       o_iq_fifo_wr_data,
    output logic                    o_noise_fifo_wr_en,
    output logic [WORD_W-1:0]       o_noise_fifo_wr_data,
    output logic                    o_busy,
    output logic                    o_user_done,
    output logic                    o_overflow
);

    logic [3:0]       state_q;
    logic [CNT_W-1:0] amounts_q;
    logic [CNT_W-1:0] half_rate_q;
    logic [CNT_W-1:0] re_cnt_q;
    logic [CNT_W-1:0] grp_cnt_q;

    logic             accept;
    logic             noise_take;
    logic             flush;
    logic [CNT_W:0]   re_next;
    logic             last_strobe;
    logic             iq_word_rdy;
    logic             noise_word_rdy;

    // A start pulse always wins: the strobe in that cycle belongs to no user.
    assign accept      = phy.data_strobe && (state_q == ST_COLLECT) && !i_user_start;
    assign re_next     = {1'b0, re_cnt_q} + (CNT_W+1)'(2);
    assign last_strobe = accept && (re_next >= {1'b0, amounts_q});
    assign noise_take  = accept && (grp_cnt_q == '0);
    assign flush       = (state_q == ST_FLUSH);

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q     <= ST_IDLE;
            amounts_q   <= '0;
            half_rate_q <= '0;
            re_cnt_q    <= '0;
            grp_cnt_q   <= '0;
        end else if (i_user_start) begin
            state_q     <= ST_COLLECT;
            amounts_q   <= i_cur_user_re_amounts;
            half_rate_q <= i_user_iq_noise_rate >> 1;
            re_cnt_q    <= '0;
            grp_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        re_cnt_q  <= re_next[CNT_W-1:0];
                        grp_cnt_q <= (grp_cnt_q == half_rate_q - 1'b1) ? '0 : grp_cnt_q + 1'b1;
                        if (last_strobe) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: state_q <= ST_DONE;
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    llr_lane_packer #(.LANE_W(IQ_LANE_W), .LANES(IQ_LANES)) u_iq_packer (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .i_clear    (i_user_start),
        .i_shift    (accept),
        .i_flush    (flush),
        .i_lane     (pack_iq_beat(phy.re0_data_i, phy.re0_data_q, phy.re1_data_i, phy.re1_data_q)),
        .o_full     (iq_word_rdy),
        .o_word     (o_iq_fifo_wr_data)
    );

    llr_lane_packer #(.LANE_W(NOISE_LANE_W), .LANES(NOISE_LANES)) u_noise_packer (
        .i_core_clk (i_core_clk),
        .i_rx_rstn  (i_rx_rstn),
        .i_clear    (i_user_start),
        .i_shift    (noise_take),
        .i_flush    (flush),
        .i_lane     (phy.noise_data),
        .o_full     (noise_word_rdy),
        .o_word     (o_noise_fifo_wr_data)
    );

    // A word meeting a full FIFO is dropped rather than stalled; the collector never backpressures.
    assign o_iq_fifo_wr_en    = iq_word_rdy && !i_iq_fifo_full;
    assign o_noise_fifo_wr_en = noise_word_rdy && !i_noise_fifo_full;

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            o_overflow <= 1'b0;
        end else if (i_user_start) begin
            o_overflow <= 1'b0;
        end else if ((iq_word_rdy && i_iq_fifo_full) || (noise_word_rdy && i_noise_fifo_full)) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_user_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_llr_slow_iq_collector.sv
// Directed bench for llr_slow_iq_collector: a reference model pushes expected FIFO words
// into queues as strobes are driven; a negedge monitor pops and compares every write.
module tb_llr_slow_iq_collector;
    import llr_slow_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             user_start = 1'b0;
    logic [CNT_W-1:0] amounts = '0;
    logic [CNT_W-1:0] rate = '0;
    logic             iq_full = 1'b0;
    logic             noise_full = 1'b0;
    logic             iq_wr_en, noise_wr_en, busy, user_done, overflow;
    logic [WORD_W-1:0] iq_wr_data, noise_wr_data;

    llr_slow_iq_collector_if phy_if ();

    llr_slow_iq_collector #(.CNT_W(CNT_W)) dut (
        .i_core_clk            (clk),
        .i_rx_rstn             (rst_n),
        .i_user_start          (user_start),
        .i_cur_user_re_amounts (amounts),
        .i_user_iq_noise_rate  (rate),
        .phy                   (phy_if.slave),
        .i_iq_fifo_full        (iq_full),
        .i_noise_fifo_full     (noise_full),
        .o_iq_fifo_wr_en       (iq_wr_en),
        .o_iq_fifo_wr_data     (iq_wr_data),
        .o_noise_fifo_wr_en    (noise_wr_en),
        .o_noise_fifo_wr_data  (noise_wr_data),
        .o_busy                (busy),
        .o_user_done           (user_done),
        .o_overflow            (overflow)
    );

    int checks = 0;
    int passed = 0;
    int iq_writes = 0;
    int noise_writes = 0;
    int done_pulses = 0;
    logic [WORD_W-1:0] iq_q[$];
    logic [WORD_W-1:0] noise_q[$];

    // Reference model of one user.
    bit           m_active = 1'b0;
    int           m_re, m_amounts, m_half, m_ncnt, m_nidx, m_iq_idx, m_iq_seq;
    int           m_drop_seq = -1;
    logic [63:0]  m_iq_lo;
    logic [127:0] m_nbuf;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_iq(input logic [127:0] w);
        if (m_iq_seq != m_drop_seq) iq_q.push_back(w);
        m_iq_seq++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (iq_wr_en) begin
                iq_writes++;
                check("iq_write_expected", 128'(iq_q.size() != 0), 128'(1));
                if (iq_q.size() != 0) check("iq_word", iq_wr_data, iq_q.pop_front());
            end
            if (noise_wr_en) begin
                noise_writes++;
                check("noise_write_expected", 128'(noise_q.size() != 0), 128'(1));
                if (noise_q.size() != 0) check("noise_word", noise_wr_data, noise_q.pop_front());
            end
            if (user_done) done_pulses++;
        end
    end

    task automatic do_start(input int a, input int r);
        @(posedge clk); #1;
        user_start = 1'b1;
        phy_if.data_strobe = 1'b0;
        amounts = CNT_W'(a);
        rate = CNT_W'(r);
        m_active = 1'b1; m_re = 0; m_amounts = a; m_half = r >> 1;
        m_ncnt = 0; m_nidx = 0; m_iq_idx = 0; m_nbuf = '0; m_iq_seq = 0;
        @(posedge clk); #1;
        user_start = 1'b0;
        amounts = CNT_W'($urandom);   // config changes mid-user must be ignored
        rate = CNT_W'($urandom);
    endtask

    task automatic do_strobe();
        logic [15:0] r0i, r0q, r1i, r1q, nz;
        @(posedge clk); #1;
        r0i = 16'($urandom); r0q = 16'($urandom); r1i = 16'($urandom); r1q = 16'($urandom);
        nz = 16'($urandom);
        phy_if.re0_data_i = r0i; phy_if.re0_data_q = r0q;
        phy_if.re1_data_i = r1i; phy_if.re1_data_q = r1q;
        phy_if.noise_data = nz;
        phy_if.data_strobe = 1'b1;
        if (m_active) begin
            m_re += 2;
            if (m_iq_idx == 0) begin
                m_iq_lo = {r1q, r1i, r0q, r0i};
                m_iq_idx = 1;
            end else begin
                push_iq({r1q, r1i, r0q, r0i, m_iq_lo});
                m_iq_idx = 0;
            end
            if (m_ncnt == 0) begin
                m_nbuf[m_nidx*16 +: 16] = nz;
                m_nidx++;
                if (m_nidx == 8) begin
                    noise_q.push_back(m_nbuf);
                    m_nbuf = '0;
                    m_nidx = 0;
                end
            end
            m_ncnt = (m_ncnt + 1 == m_half) ? 0 : m_ncnt + 1;
            if (m_re >= m_amounts) begin
                if (m_iq_idx != 0) push_iq({64'd0, m_iq_lo});
                if (m_nidx != 0) noise_q.push_back(m_nbuf);
                m_active = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            phy_if.data_strobe = 1'b0;
        end
    endtask

    // Called in the cycle after the final strobe (FLUSH).
    task automatic finish_user(input string tag);
        @(negedge clk);
        check({tag, "_flush_busy"}, 128'(busy), 128'(1));
        check({tag, "_flush_no_done"}, 128'(user_done), 128'(0));
        @(negedge clk);
        check({tag, "_done"}, 128'(user_done), 128'(1));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 128'(user_done), 128'(0));
        check({tag, "_idle"}, 128'(busy), 128'(0));
        check({tag, "_iq_q_drained"}, 128'(iq_q.size()), 128'(0));
        check({tag, "_noise_q_drained"}, 128'(noise_q.size()), 128'(0));
    endtask

    initial begin
        int iq0, nz0, dn0;
        phy_if.data_strobe = 1'b0;
        phy_if.re0_data_i = '0; phy_if.re0_data_q = '0;
        phy_if.re1_data_i = '0; phy_if.re1_data_q = '0;
        phy_if.noise_data = '0;

        // Reset state
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(user_done), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_iq_wr", 128'(iq_wr_en), 128'(0));
        check("rst_iq_data", iq_wr_data, 128'(0));
        check("rst_noise_data", noise_wr_data, 128'(0));
        #5 rst_n = 1'b1;

        // 1: amounts=8, rate=2, back-to-back
        iq0 = iq_writes; nz0 = noise_writes;
        do_start(8, 2);
        check("t1_busy", 128'(busy), 128'(1));
        repeat (4) do_strobe();
        idle(1);
        finish_user("t1");
        check("t1_iq_writes", 128'(iq_writes - iq0), 128'(2));
        check("t1_noise_writes", 128'(noise_writes - nz0), 128'(1));

        // 2: amounts=6, rate=4, strobe every other cycle
        iq0 = iq_writes; nz0 = noise_writes;
        do_start(6, 4);
        repeat (3) begin do_strobe(); idle(1); end
        finish_user("t2");
        check("t2_iq_writes", 128'(iq_writes - iq0), 128'(2));
        check("t2_noise_writes", 128'(noise_writes - nz0), 128'(1));

        // 3: amounts=32, rate=2, IQ FIFO full while the 2nd word is written
        iq0 = iq_writes;
        do_start(32, 2);
        m_drop_seq = 1;
        for (int i = 0; i < 16; i++) begin
            do_strobe();
            iq_full = (i == 4);
        end
        idle(1);
        iq_full = 1'b0;
        finish_user("t3");
        check("t3_overflow", 128'(overflow), 128'(1));
        check("t3_iq_writes", 128'(iq_writes - iq0), 128'(7));
        m_drop_seq = -1;

        // 4: restart mid-COLLECT after 3 strobes
        iq0 = iq_writes; dn0 = done_pulses;
        do_start(16, 4);
        check("t4_ovf_cleared", 128'(overflow), 128'(0));
        repeat (3) do_strobe();
        do_start(4, 2);   // model discards the stale partial word
        repeat (2) do_strobe();
        idle(1);
        finish_user("t4");
        check("t4_iq_writes", 128'(iq_writes - iq0), 128'(2));
        check("t4_one_done", 128'(done_pulses - dn0), 128'(1));

        // 5: noise word completes on the final strobe, nothing left to flush
        iq0 = iq_writes; nz0 = noise_writes;
        do_start(32, 2);
        repeat (16) do_strobe();
        idle(1);
        finish_user("t5");
        check("t5_iq_writes", 128'(iq_writes - iq0), 128'(8));
        check("t5_noise_writes", 128'(noise_writes - nz0), 128'(2));

        // 6: asynchronous reset mid-user
        dn0 = done_pulses;
        do_start(16, 2);
        repeat (3) do_strobe();
        idle(1);
        check("t6_busy_before", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        m_active = 1'b0;
        #1;
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_iq_wr", 128'(iq_wr_en), 128'(0));
        check("t6_rst_noise_wr", 128'(noise_wr_en), 128'(0));
        check("t6_rst_iq_data", iq_wr_data, 128'(0));
        check("t6_rst_done", 128'(user_done), 128'(0));
        check("t6_iq_q_empty", 128'(iq_q.size()), 128'(0));
        #4 rst_n = 1'b1;
        iq0 = iq_writes; nz0 = noise_writes;
        repeat (4) do_strobe();
        idle(3);
        check("t6_no_iq_writes", 128'(iq_writes - iq0), 128'(0));
        check("t6_no_noise_writes", 128'(noise_writes - nz0), 128'(0));
        check("t6_idle", 128'(busy), 128'(0));
        check("t6_no_done", 128'(done_pulses - dn0), 128'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
